// File: rtl/bsg_manycore_ruche_bypass_buffer.sv
// Retiming FIFOs for the pass-through ruche channels 1..ruche_factor_X_p-1 of a ruche tile.
// Direction index: 0 = W, 1 = E. Input [i][W] drains to output [i][E] and vice versa.

module bsg_manycore_ruche_bypass_lane
  #(parameter int width_p       = 8
    , parameter int els_p       = 2
    , parameter bit use_credits_p = 1'b0
    , parameter int credit_els_p = 2
    , localparam int ptr_w_lp   = $clog2(els_p)
    , localparam int cnt_w_lp   = $clog2(els_p+1)
    , localparam int cred_w_lp  = $clog2(credit_els_p+1))
   (input  logic                 clk_i
    , input  logic                 reset_i
    , input  logic                 v_i
    , input  logic [width_p-1:0]   data_i
    , output logic                 ready_o
    , output logic                 v_o
    , output logic [width_p-1:0]   data_o
    , input  logic                 ready_i
    , output logic [cnt_w_lp-1:0]  occupancy_o);

    logic [els_p-1:0][width_p-1:0] mem_r;
    logic [ptr_w_lp-1:0]  wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0]  count_r;
    logic [cred_w_lp-1:0] credits_r;
    logic enq, deq, credit_ok;

    assign ready_o     = ~reset_i & (count_r != cnt_w_lp'(els_p));
    assign credit_ok   = use_credits_p ? (credits_r != '0) : 1'b1;
    assign v_o         = ~reset_i & (count_r != '0) & credit_ok;
    assign data_o      = mem_r[rd_ptr_r];
    assign occupancy_o = reset_i ? '0 : count_r;

    assign enq = v_i & ready_o;
    // In credit mode every valid cycle is a send; ready_i only returns credits.
    assign deq = v_o & (use_credits_p | ready_i);

    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wr_ptr_r] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq)
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(els_p-1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            if (deq)
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p-1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            if (enq & ~deq)
                count_r <= count_r + cnt_w_lp'(1);
            else if (~enq & deq)
                count_r <= count_r - cnt_w_lp'(1);
        end
    end

    // A return with the counter already full is dropped so the count never overflows.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            credits_r <= cred_w_lp'(credit_els_p);
        else if (use_credits_p) begin
            if (deq & ~ready_i)
                credits_r <= credits_r - cred_w_lp'(1);
            else if (~deq & ready_i & (credits_r != cred_w_lp'(credit_els_p)))
                credits_r <= credits_r + cred_w_lp'(1);
        end
    end

    if (use_credits_p) begin : g_credit_chk
        credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
            !(ready_i && credits_r == cred_w_lp'(credit_els_p)));
    end

endmodule

module bsg_manycore_ruche_bypass_buffer
  #(parameter int width_p          = 8
    , parameter int ruche_factor_X_p = 3
    , parameter int els_p          = 2
    , parameter logic [2*(ruche_factor_X_p-1)-1:0] use_credits_p = '0
    , parameter int credit_els_p   = 2
    , localparam int lanes_lp      = 2*(ruche_factor_X_p-1)
    , localparam int occ_w_lp      = $clog2(els_p+1))
   (input  logic                                                clk_i
    , input  logic                                                reset_i
    , input  logic [ruche_factor_X_p-1:1][1:0]                    v_i
    , input  logic [ruche_factor_X_p-1:1][1:0][width_p-1:0]       data_i
    , output logic [ruche_factor_X_p-1:1][1:0]                    ready_o
    , output logic [ruche_factor_X_p-1:1][1:0]                    v_o
    , output logic [ruche_factor_X_p-1:1][1:0][width_p-1:0]       data_o
    , input  logic [ruche_factor_X_p-1:1][1:0]                    ready_i
    , output logic [ruche_factor_X_p-1:1][1:0][occ_w_lp-1:0]      occupancy_o);

    // Lane state, use_credits_p bits, ready_i and occupancy_o are indexed by the output side.
    for (genvar i = 1; i < ruche_factor_X_p; i++) begin : g_ch
        for (genvar d = 0; d < 2; d++) begin : g_dir
            localparam int o_lp = 1 - d;
            localparam int bit_lp = (i-1)*2 + o_lp;

            bsg_manycore_ruche_bypass_lane
              #(.width_p(width_p)
                ,.els_p(els_p)
                ,.use_credits_p(use_credits_p[bit_lp])
                ,.credit_els_p(credit_els_p))
            lane
              (.clk_i(clk_i)
               ,.reset_i(reset_i)
               ,.v_i(v_i[i][d])
               ,.data_i(data_i[i][d])
               ,.ready_o(ready_o[i][d])
               ,.v_o(v_o[i][o_lp])
               ,.data_o(data_o[i][o_lp])
               ,.ready_i(ready_i[i][o_lp])
               ,.occupancy_o(occupancy_o[i][o_lp]));
        end
    end

endmodule

// File: tb/tb_bsg_manycore_ruche_bypass_buffer.sv
// Directed bench for the ruche bypass buffer: 6 lanes, els_p = 2, output [2][W] in credit mode.

module tb_bsg_manycore_ruche_bypass_buffer;

    logic clk, reset_i;
    logic [3:1][1:0]            v_i, ready_o, v_o, ready_i;
    logic [3:1][1:0][7:0]       data_i, data_o;
    logic [3:1][1:0][1:0]       occupancy_o;

    int n_chk = 0;
    int n_fail = 0;

    bsg_manycore_ruche_bypass_buffer
      #(.width_p(8), .ruche_factor_X_p(4), .els_p(2)
        ,.use_credits_p(6'b000100), .credit_els_p(2))
    dut
      (.clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o)
       ,.v_o(v_o), .data_o(data_o), .ready_i(ready_i), .occupancy_o(occupancy_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, v;
        logic [7:0] d;
        logic       r;
        logic       e_rdy, e_v;
        logic [7:0] e_d;
        logic [1:0] e_occ;
    } vec_t;

    vec_t tv[14];
    vec_t cv[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one row on input [i][d] / output [i][1-d], then check the pre-edge outputs.
    task automatic apply(input string nm, input int i, input int d, input vec_t t);
        @(negedge clk);
        reset_i        = t.rst;
        v_i[i][d]      = t.v;
        data_i[i][d]   = t.d;
        ready_i[i][1-d] = t.r;
        #1;
        chk($sformatf("%s ready_o", nm), 32'(ready_o[i][d]), 32'(t.e_rdy));
        chk($sformatf("%s v_o", nm), 32'(v_o[i][1-d]), 32'(t.e_v));
        if (t.e_v)
            chk($sformatf("%s data_o", nm), 32'(data_o[i][1-d]), 32'(t.e_d));
        chk($sformatf("%s occupancy", nm), 32'(occupancy_o[i][1-d]), 32'(t.e_occ));
    endtask

    function automatic logic [7:0] tag(input int i, input int d, input int s);
        return 8'((i*2 + d)*32 + s);
    endfunction

    initial begin
        int seq_in[3:1][1:0];
        int seq_out[3:1][1:0];
        logic prev_send;
        logic deq;

        reset_i = 1'b1;
        v_i = '0;
        data_i = '0;
        ready_i = '0;

        //           rst v  d      r  rdy v  data   occ
        tv[0]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        tv[1]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        tv[2]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        tv[3]  = '{0, 1, 8'hA5, 0, 1, 0, 8'h00, 0};
        tv[4]  = '{0, 0, 8'h00, 0, 1, 1, 8'hA5, 1};
        tv[5]  = '{0, 0, 8'h00, 1, 1, 1, 8'hA5, 1};
        tv[6]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0};
        tv[7]  = '{0, 1, 8'h01, 0, 1, 0, 8'h00, 0};
        tv[8]  = '{0, 1, 8'h02, 0, 1, 1, 8'h01, 1};
        tv[9]  = '{0, 1, 8'h03, 0, 0, 1, 8'h01, 2};
        tv[10] = '{0, 1, 8'h03, 1, 0, 1, 8'h01, 2};
        tv[11] = '{0, 1, 8'h03, 1, 1, 1, 8'h02, 1};
        tv[12] = '{0, 0, 8'h00, 1, 1, 1, 8'h03, 1};
        tv[13] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0};

        // Credit lane: input [2][E] -> output [2][W], 2 credits.
        cv[0]  = '{0, 1, 8'hC0, 0, 1, 0, 8'h00, 0};
        cv[1]  = '{0, 1, 8'hC1, 0, 1, 1, 8'hC0, 1};
        cv[2]  = '{0, 1, 8'hC2, 0, 1, 1, 8'hC1, 1};
        cv[3]  = '{0, 1, 8'hC3, 0, 1, 0, 8'h00, 1};
        cv[4]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 2};
        cv[5]  = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 2};
        cv[6]  = '{0, 0, 8'h00, 0, 0, 1, 8'hC2, 2};
        cv[7]  = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 1};
        cv[8]  = '{0, 0, 8'h00, 1, 1, 1, 8'hC3, 1};
        cv[9]  = '{0, 1, 8'hC4, 0, 1, 0, 8'h00, 0};
        cv[10] = '{0, 0, 8'h00, 0, 1, 1, 8'hC4, 1};
        cv[11] = '{0, 1, 8'hD0, 0, 1, 0, 8'h00, 0};
        cv[12] = '{0, 1, 8'hD1, 0, 1, 0, 8'h00, 1};
        cv[13] = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        cv[14] = '{0, 1, 8'hE0, 0, 1, 0, 8'h00, 0};
        cv[15] = '{0, 1, 8'hE1, 0, 1, 1, 8'hE0, 1};
        cv[16] = '{0, 0, 8'h00, 0, 1, 1, 8'hE1, 1};
        cv[17] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0};

        // Reset, single packet, fill/backpressure on input [1][W] -> output [1][E].
        for (int n = 0; n < 14; n++)
            apply($sformatf("basic[%0d]", n), 1, 0, tv[n]);

        // Streaming with pointer wrap.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            v_i[1][0]     = (k < 10);
            data_i[1][0]  = 8'(k);
            ready_i[1][1] = 1'b1;
            #1;
            if (k == 0)
                chk("stream v_o first", 32'(v_o[1][1]), 32'd0);
            else begin
                chk($sformatf("stream[%0d] v_o", k), 32'(v_o[1][1]), 32'd1);
                chk($sformatf("stream[%0d] data_o", k), 32'(data_o[1][1]), 32'(k-1));
                chk($sformatf("stream[%0d] occupancy", k), 32'(occupancy_o[1][1]), 32'd1);
            end
        end
        @(negedge clk);
        v_i = '0;
        ready_i = '0;
        #1;
        chk("stream drained occupancy", 32'(occupancy_o[1][1]), 32'd0);

        // Credit mode and mid-operation reset.
        for (int n = 0; n < 18; n++)
            apply($sformatf("credit[%0d]", n), 2, 1, cv[n]);

        // Lane independence: all 6 lanes stream, output [2][E] stalled.
        @(negedge clk);
        v_i = '0;
        ready_i = '0;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        for (int i = 1; i <= 3; i++)
            for (int d = 0; d < 2; d++) begin
                seq_in[i][d] = 0;
                seq_out[i][d] = 0;
            end
        prev_send = 1'b0;
        for (int k = 0; k < 12; k++) begin
            for (int i = 1; i <= 3; i++)
                for (int d = 0; d < 2; d++) begin
                    v_i[i][d]     = 1'b1;
                    data_i[i][d]  = tag(i, d, seq_in[i][d]);
                    ready_i[i][d] = !(i == 2 && d == 1);
                end
            ready_i[2][0] = prev_send;
            #1;
            for (int i = 1; i <= 3; i++)
                for (int o = 0; o < 2; o++) begin
                    if (!(i == 2 && o == 1)) begin
                        if (k > 0)
                            chk($sformatf("indep[%0d] v_o[%0d][%0d]", k, i, o), 32'(v_o[i][o]), 32'd1);
                        if (v_o[i][o])
                            chk($sformatf("indep[%0d] data_o[%0d][%0d]", k, i, o),
                                32'(data_o[i][o]), 32'(tag(i, 1-o, seq_out[i][o])));
                        deq = v_o[i][o] & ((i == 2 && o == 0) | ready_i[i][o]);
                        if (deq)
                            seq_out[i][o]++;
                    end
                end
            for (int i = 1; i <= 3; i++)
                for (int d = 0; d < 2; d++) begin
                    if (!(i == 2 && d == 0))
                        chk($sformatf("indep[%0d] ready_o[%0d][%0d]", k, i, d), 32'(ready_o[i][d]), 32'd1);
                    if (ready_o[i][d])
                        seq_in[i][d]++;
                end
            prev_send = v_o[2][0];
            @(negedge clk);
        end
        #1;
        chk("stalled occupancy", 32'(occupancy_o[2][1]), 32'd2);
        chk("stalled v_o", 32'(v_o[2][1]), 32'd1);
        chk("stalled data_o", 32'(data_o[2][1]), 32'(tag(2, 0, 0)));
        chk("stalled ready_o", 32'(ready_o[2][0]), 32'd0);
        chk("stream count lane [1][E]", 32'(seq_out[1][1]), 32'd11);

        v_i = '0;
        ready_i = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_ruche_bypass_buffer.md
Name: bsg_manycore_ruche_bypass_buffer

Overview:
Buffers the pass-through ruche channels 1..ruche_factor_X_p-1 of a ruche tile. Until now these channels were bare wires from one side of the tile to the other; this block adds one registered, depth-configurable FIFO per directional lane, so long ruche hops are retimed at every tile. Each lane is independently configurable as ready_and or credit-return on its output side. Instantiated inside the ruche tile beside the mesh router; ruche channel 0 still terminates at the router and does not pass through this block.

Parameters:
width_p, "inv", payload width of one lane (one packet).
ruche_factor_X_p, 3, ruche factor; must be >= 2; lanes_lp = 2*(ruche_factor_X_p-1).
els_p, 2, FIFO depth per lane; must be >= 2.
use_credits_p, {lanes_lp{1'b0}}, per-lane bit; 1 = output side uses the credit protocol.
credit_els_p, 2, initial (= maximum) credit count for credit-mode lanes; must be >= 1.

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous, active-high reset
v_i  input  [ruche_factor_X_p-1:1][E:W]  per-lane input valid
data_i  input  [ruche_factor_X_p-1:1][E:W][width_p]  per-lane input payload
ready_o  output  [ruche_factor_X_p-1:1][E:W]  per-lane input ready_and
v_o  output  [ruche_factor_X_p-1:1][E:W]  per-lane output valid
data_o  output  [ruche_factor_X_p-1:1][E:W][width_p]  per-lane output payload
ready_i  input  [ruche_factor_X_p-1:1][E:W]  ready_and (ready mode) or credit-return pulse (credit mode)
occupancy_o  output  [ruche_factor_X_p-1:1][E:W][clog2(els_p+1)]  per-lane entry count

Behaviour:
- Lane crossing: input [i][W] drains to output [i][E]; input [i][E] drains to output [i][W]. The two directions of a channel are independent lanes.
- Per-lane state: circular buffer of els_p entries; wr_ptr and rd_ptr wrap from els_p-1 to 0; count in 0..els_p; credit counter in 0..credit_els_p (credit-mode lanes only).
- Reset, while reset_i is high:
  - pointers = 0, count = 0, credits = credit_els_p.
  - v_o = 0, ready_o = 0, occupancy_o = 0.
  - Reset mid-operation discards all buffered packets.
  - Memory contents are don't-care; data_o is don't-care while v_o = 0.
- Input handshake:
  - ready_o = ~reset_i & (count != els_p).
  - ready_o is driven from registers only; there is no combinational path from ready_i.
  - Enqueue when v_i & ready_o. data_i is written at wr_ptr, and wr_ptr advances.
  - v_i while ready_o = 0 is ignored. The upstream holds the packet.
- Output, ready mode (use_credits_p bit = 0):
  - v_o = (count != 0).
  - data_o = mem[rd_ptr].
  - Dequeue when v_o & ready_i.
- Output, credit mode (use_credits_p bit = 1):
  - v_o = (count != 0) & (credits != 0).
  - Every cycle v_o is high counts as a send and dequeues.
  - ready_i is a one-cycle credit return.
  - credits' = credits - send + ready_i. A simultaneous send and return leaves credits unchanged.
  - A return while credits == credit_els_p is a protocol error: simulation assertion; the counter saturates.
- Latency: minimum 1 cycle. A packet accepted at edge N is visible on v_o/data_o after edge N, with no bypass when empty. Throughput is 1 packet per cycle per lane when not backpressured.
- Full: enqueue and dequeue in the same cycle cannot occur, because ready_o is low. After the dequeue, ready_o rises in the next cycle.
- Empty: v_o = 0, and ready_i in ready mode is ignored.
- Simultaneous enqueue and dequeue when 0 < count < els_p: count is unchanged and both pointers advance.
- Ordering: strict FIFO per lane; no interaction between lanes.
- occupancy_o = count, registered.

Test Plan:
1. Reset then single packet:
   - reset_i high for 3 cycles: v_o = 0, ready_o = 0.
   - Release reset; enqueue 0xA5 on lane [1][W].
   - v_o[1][E] = 1 with data 0xA5 one cycle later; occupancy 1 -> 0 after ready_i.
2. Fill and backpressure, els_p = 2, ready mode, ready_i = 0:
   - Enqueue 0x1 and 0x2; ready_o drops after the 2nd.
   - A 3rd v_i is held and not accepted.
   - Raise ready_i: 0x1 then 0x2 out in order; ready_o returns 1 cycle after the first dequeue.
3. Streaming with pointer wrap:
   - v_i and ready_i held high for 10 packets 0..9.
   - Output is 0..9 in order at 1 per cycle; occupancy stays 1; pointers wrap without loss.
4. Credit mode, credit_els_p = 2, 4 packets buffered:
   - Exactly 2 sends, then v_o = 0.
   - Pulse ready_i once: 1 more send.
   - Credit return and send in the same cycle: credits unchanged.
5. Reset mid-operation:
   - Lane holds 2 packets; assert reset_i for 1 cycle.
   - occupancy = 0 and v_o = 0 next cycle; credits restored to 2.
6. Lane independence, ruche_factor_X_p = 4 (6 lanes):
   - Distinct tags on every lane; stall lane [2][E] only.
   - The other 5 lanes stream uninterrupted; each tag appears only on its crossed output.
